vga_scan_driver: RTL

//  Raster timing generator and pixel output stage for the VGA display path.

---
 rtl/vga_scan_driver.sv | 86 ++++++++
 1 files changed

// File: rtl/vga_scan_driver.sv
// vga_scan_driver: VGA raster timing generator with a one-pixel output stage
// that re-aligns sync/blank with the colour returned by the pixel mux.
module vga_scan_driver #(
    parameter int   H_ACTIVE = 640,
    parameter int   H_FP     = 16,
    parameter int   H_SYNC   = 96,
    parameter int   H_BP     = 48,
    parameter int   V_ACTIVE = 480,
    parameter int   V_FP     = 10,
    parameter int   V_SYNC   = 2,
    parameter int   V_BP     = 33,
    parameter int   CLK_DIV  = 2,
    parameter logic HS_POL   = 1'b0,
    parameter logic VS_POL   = 1'b0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [7:0]  r_in,
    input  logic [7:0]  g_in,
    input  logic [7:0]  b_in,
    output logic [18:0] curr_pos,
    output logic        active,
    output logic [7:0]  vga_r,
    output logic [7:0]  vga_g,
    output logic [7:0]  vga_b,
    output logic        vga_hs,
    output logic        vga_vs,
    output logic        vga_blank_n,
    output logic        vga_clk,
    output logic        frame_start
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [DW-1:0] r_div_cnt;
    logic [9:0]    r_h_cnt;
    logic [9:0]    r_v_cnt;
    logic          w_pix_tick;
    logic          w_h_last;
    logic          w_v_last;
    logic          w_hs0;
    logic          w_vs0;
    logic [DW-1:0] w_div_next;

    assign w_pix_tick = r_div_cnt == DW'(CLK_DIV - 1);
    assign w_h_last   = r_h_cnt == 10'(H_TOTAL - 1);
    assign w_v_last   = r_v_cnt == 10'(V_TOTAL - 1);
    assign w_div_next = w_pix_tick ? '0 : r_div_cnt + DW'(1);
    assign w_hs0      = (r_h_cnt >= 10'(H_ACTIVE + H_FP)) && (r_h_cnt < 10'(H_ACTIVE + H_FP + H_SYNC));
    assign w_vs0      = (r_v_cnt >= 10'(V_ACTIVE + V_FP)) && (r_v_cnt < 10'(V_ACTIVE + V_FP + V_SYNC));
    assign active     = (r_h_cnt < 10'(H_ACTIVE)) && (r_v_cnt < 10'(V_ACTIVE));
    // Blanked coordinates read as 0 so v_cnt >= 512 never aliases into y[8:0].
    assign curr_pos   = active ? {r_h_cnt, r_v_cnt[8:0]} : 19'd0;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_div_cnt   <= '0;
            r_h_cnt     <= '0;
            r_v_cnt     <= '0;
            vga_r       <= 8'd0;
            vga_g       <= 8'd0;
            vga_b       <= 8'd0;
            vga_blank_n <= 1'b0;
            vga_hs      <= ~HS_POL;
            vga_vs      <= ~VS_POL;
            vga_clk     <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            r_div_cnt   <= w_div_next;
            vga_clk     <= w_div_next >= DW'(CLK_DIV / 2);
            frame_start <= w_pix_tick && w_h_last && w_v_last;
            if (w_pix_tick) begin
                r_h_cnt     <= w_h_last ? 10'd0 : r_h_cnt + 10'd1;
                if (w_h_last)
                    r_v_cnt <= w_v_last ? 10'd0 : r_v_cnt + 10'd1;
                vga_r       <= active ? r_in : 8'd0;
                vga_g       <= active ? g_in : 8'd0;
                vga_b       <= active ? b_in : 8'd0;
                vga_blank_n <= active;
                vga_hs      <= w_hs0 ? HS_POL : ~HS_POL;
                vga_vs      <= w_vs0 ? VS_POL : ~VS_POL;
            end
        end
    end
endmodule
